// File: rtl/run_segmenter.sv
// Run segmenter: finds horizontal runs of set pixels in a binary mask stream,
// bridging short gaps of clear pixels, and reports start, end and per-line count.
// All outputs are registered one cycle after the causing pixel; i_valid low stalls everything.
module run_segmenter #(
  parameter int MIN_LEN = 4,
  parameter int MAX_GAP = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_valid,
  input  logic       i_pixel,
  input  logic [9:0] i_x,
  input  logic [8:0] i_y,
  input  logic       i_eol,
  output logic       o_start,
  output logic       o_finish,
  output logic [9:0] o_left_edge,
  output logic [8:0] o_y,
  output logic [9:0] o_run_len,
  output logic [7:0] o_run_count,
  output logic       o_line_done
);

  localparam logic [4:0] MIN_LEN_C = 5'(MIN_LEN);
  localparam logic [3:0] MAX_GAP_C = 4'(MAX_GAP);

  typedef enum logic [1:0] {IDLE, CAND, RUN, GAP} state_t;

  state_t     state_q, state_d;
  logic [9:0] left_q, left_d;
  logic [9:0] right_q, right_d;
  logic [8:0] y_q, y_d;
  logic [3:0] len_q, len_d;
  logic [2:0] gap_q, gap_d;
  // Set at end of line; the next pixel clears the run counter.
  logic       new_line_q, new_line_d;
  // A run confirmed and closed by the same eol pixel finishes one cycle later.
  logic       fin_pend_q, fin_pend_d;

  logic       start_q, start_d;
  logic       finish_q, finish_d;
  logic       done_q, done_d;
  logic [9:0] left_edge_q, left_edge_d;
  logic [8:0] oy_q, oy_d;
  logic [9:0] run_len_q, run_len_d;
  logic [7:0] count_q, count_d;

  logic       confirm;
  logic       close;
  logic [7:0] count_base;

  // Next-state: process the pixel, then apply end-of-line, close and confirm side effects.
  always_comb begin
    state_d     = state_q;
    left_d      = left_q;
    right_d     = right_q;
    y_d         = y_q;
    len_d       = len_q;
    gap_d       = gap_q;
    new_line_d  = new_line_q;
    fin_pend_d  = 1'b0;
    start_d     = 1'b0;
    finish_d    = 1'b0;
    done_d      = 1'b0;
    left_edge_d = left_edge_q;
    oy_d        = oy_q;
    run_len_d   = run_len_q;
    count_d     = count_q;
    confirm     = 1'b0;
    close       = 1'b0;
    count_base  = count_q;

    if (fin_pend_q) begin
      finish_d  = 1'b1;
      done_d    = 1'b1;
      run_len_d = right_q - left_q + 10'd1;
    end

    if (i_valid) begin
      // Keep the count visible through a deferred line_done before clearing it.
      if (new_line_q && !fin_pend_q) begin
        count_base = 8'd0;
        new_line_d = 1'b0;
      end
      count_d = count_base;

      unique case (state_q)
        IDLE: begin
          if (i_pixel) begin
            left_d  = i_x;
            right_d = i_x;
            y_d     = i_y;
            len_d   = 4'd1;
            if (MIN_LEN_C == 5'd1) begin
              confirm = 1'b1;
              state_d = RUN;
            end else begin
              state_d = CAND;
            end
          end
        end
        CAND: begin
          if (i_pixel) begin
            len_d   = len_q + 4'd1;
            right_d = i_x;
            if ({1'b0, len_q} + 5'd1 >= MIN_LEN_C) begin
              confirm = 1'b1;
              state_d = RUN;
            end
          end else begin
            state_d = IDLE;
          end
        end
        RUN: begin
          if (i_pixel) begin
            right_d = i_x;
          end else if (MAX_GAP_C == 4'd0) begin
            close = 1'b1;
          end else begin
            gap_d   = 3'd1;
            state_d = GAP;
          end
        end
        GAP: begin
          if (i_pixel) begin
            right_d = i_x;
            gap_d   = 3'd0;
            state_d = RUN;
          end else begin
            gap_d = gap_q + 3'd1;
            if ({1'b0, gap_q} + 4'd1 > MAX_GAP_C) close = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase

      if (i_eol) begin
        if (confirm) begin
          fin_pend_d = 1'b1;
        end else begin
          if (state_d == RUN || state_d == GAP) close = 1'b1;
          done_d = 1'b1;
        end
        state_d    = IDLE;
        new_line_d = 1'b1;
      end

      if (close) begin
        finish_d  = 1'b1;
        run_len_d = right_d - left_d + 10'd1;
        state_d   = IDLE;
      end

      if (confirm) begin
        start_d     = 1'b1;
        left_edge_d = left_d;
        oy_d        = y_d;
        count_d     = (count_base == 8'hFF) ? count_base : count_base + 8'd1;
      end
    end
  end

  // State and registered outputs; reset drops any run in flight without a finish.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      left_q      <= '0;
      right_q     <= '0;
      y_q         <= '0;
      len_q       <= '0;
      gap_q       <= '0;
      new_line_q  <= 1'b0;
      fin_pend_q  <= 1'b0;
      start_q     <= 1'b0;
      finish_q    <= 1'b0;
      done_q      <= 1'b0;
      left_edge_q <= '0;
      oy_q        <= '0;
      run_len_q   <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      left_q      <= left_d;
      right_q     <= right_d;
      y_q         <= y_d;
      len_q       <= len_d;
      gap_q       <= gap_d;
      new_line_q  <= new_line_d;
      fin_pend_q  <= fin_pend_d;
      start_q     <= start_d;
      finish_q    <= finish_d;
      done_q      <= done_d;
      left_edge_q <= left_edge_d;
      oy_q        <= oy_d;
      run_len_q   <= run_len_d;
      count_q     <= count_d;
    end
  end

  assign o_start     = start_q;
  assign o_finish    = finish_q;
  assign o_line_done = done_q;
  assign o_left_edge = left_edge_q;
  assign o_y         = oy_q;
  assign o_run_len   = run_len_q;
  assign o_run_count = count_q;

endmodule

// File: tb/tb_run_segmenter.sv
// Bench for run_segmenter: full 640-pixel lines against a segment-level reference
// model, plus literal pins on the reference runs, reset and stall behaviour.
module tb_run_segmenter;

  localparam int MIN_LEN = 4;
  localparam int MAX_GAP = 2;
  localparam int W = 640;

  logic       clk = 1'b0;
  logic       rst;
  logic       i_valid, i_pixel, i_eol;
  logic [9:0] i_x;
  logic [8:0] i_y;
  logic       o_start, o_finish, o_line_done;
  logic [9:0] o_left_edge, o_run_len;
  logic [8:0] o_y;
  logic [7:0] o_run_count;

  always #5 clk = ~clk;

  run_segmenter #(.MIN_LEN(MIN_LEN), .MAX_GAP(MAX_GAP)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_pixel(i_pixel), .i_x(i_x), .i_y(i_y),
    .i_eol(i_eol), .o_start(o_start), .o_finish(o_finish), .o_left_edge(o_left_edge),
    .o_y(o_y), .o_run_len(o_run_len), .o_run_count(o_run_count), .o_line_done(o_line_done)
  );

  int vectors = 0;
  int miscompares = 0;
  int ecnt = 0;
  bit chk_en = 1'b0;
  bit pix[W];

  // Expected and observed events, keyed by the clock edge whose outputs carry them.
  int exp_s_left[int], exp_s_y[int], exp_s_cnt[int], exp_f_len[int], exp_d_cnt[int];
  int got_s_left[int], got_s_y[int], got_f_len[int], got_d_cnt[int];

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, ecnt);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    ecnt++;
    #1;
  endtask

  task automatic idle(input int n);
    i_valid = 1'b0;
    i_eol   = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clear_pix();
    for (int i = 0; i < W; i++) pix[i] = 1'b0;
  endtask

  task automatic set_ones(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) pix[i] = 1'b1;
  endtask

  // Segment-level reference: maximal runs of 1s; a segment of at least MIN_LEN
  // opens a run, later segments join it while the zero gap is at most MAX_GAP.
  task automatic model_line(input int y, input int base, input int stall_at, input int stall_len);
    int ed[W];
    int e = base;
    int k = 0;
    int s, t, cp, fe;
    int left = 0, right = 0, cnt = 0, cpix = -1;
    bit in_run = 1'b0;
    for (int i = 0; i < W; i++) begin
      if (i == stall_at) e += stall_len;
      ed[i] = e;
      e++;
    end
    while (k < W) begin
      if (!pix[k]) begin
        k++;
      end else begin
        s = k;
        while (k < W && pix[k]) k++;
        t = k - 1;
        if (in_run && (s - right - 1) <= MAX_GAP) begin
          right = t;
        end else begin
          if (in_run) begin
            exp_f_len[ed[right + MAX_GAP + 1]] = right - left + 1;
            in_run = 1'b0;
          end
          if (t - s + 1 >= MIN_LEN) begin
            cnt  = (cnt < 255) ? cnt + 1 : 255;
            cpix = s + MIN_LEN - 1;
            exp_s_left[ed[cpix]] = s;
            exp_s_y[ed[cpix]]    = y;
            exp_s_cnt[ed[cpix]]  = cnt;
            in_run = 1'b1;
            left   = s;
            right  = t;
          end
        end
      end
    end
    fe = ed[W - 1];
    if (in_run) begin
      cp = right + MAX_GAP + 1;
      if (cp <= W - 1) begin
        exp_f_len[ed[cp]] = right - left + 1;
      end else begin
        if (cpix == W - 1) fe++;
        exp_f_len[fe] = right - left + 1;
      end
    end
    exp_d_cnt[fe] = cnt;
  endtask

  task automatic drive_line(input int y, input int stall_at, input int stall_len, output int base);
    base = ecnt + 1;
    model_line(y, base, stall_at, stall_len);
    for (int k = 0; k < W; k++) begin
      if (k == stall_at) begin
        for (int s = 0; s < stall_len; s++) begin
          i_valid = 1'b0;
          i_pixel = ~pix[k];
          i_eol   = 1'b0;
          tick();
        end
      end
      i_valid = 1'b1;
      i_pixel = pix[k];
      i_x     = 10'(k);
      i_y     = 9'(y);
      i_eol   = (k == W - 1);
      tick();
    end
    i_valid = 1'b0;
    i_eol   = 1'b0;
  endtask

  function automatic int got(input int which, input int e);
    case (which)
      0: return got_s_left.exists(e) ? got_s_left[e] : -1;
      1: return got_s_y.exists(e) ? got_s_y[e] : -1;
      2: return got_f_len.exists(e) ? got_f_len[e] : -1;
      default: return got_d_cnt.exists(e) ? got_d_cnt[e] : -1;
    endcase
  endfunction

  function automatic int n_events(input int lo, input int hi);
    int n = 0;
    for (int e = lo; e <= hi; e++) n += int'(got_s_left.exists(e)) + int'(got_f_len.exists(e));
    return n;
  endfunction

  int b1, b2, b3, b4, b5, b6, b8;

  initial begin
    rst = 1'b1; i_valid = 1'b0; i_pixel = 1'b0; i_eol = 1'b0; i_x = '0; i_y = '0;

    fork
      forever begin
        @(negedge clk);
        if (o_start) begin got_s_left[ecnt] = int'(o_left_edge); got_s_y[ecnt] = int'(o_y); end
        if (o_finish) got_f_len[ecnt] = int'(o_run_len);
        if (o_line_done) got_d_cnt[ecnt] = int'(o_run_count);
        if (chk_en) begin
          chk("start_pulse", int'(o_start), int'(exp_s_left.exists(ecnt)));
          chk("finish_pulse", int'(o_finish), int'(exp_f_len.exists(ecnt)));
          chk("line_done_pulse", int'(o_line_done), int'(exp_d_cnt.exists(ecnt)));
          if (exp_s_left.exists(ecnt)) begin
            chk("left_edge", int'(o_left_edge), exp_s_left[ecnt]);
            chk("run_y", int'(o_y), exp_s_y[ecnt]);
            chk("count_at_start", int'(o_run_count), exp_s_cnt[ecnt]);
          end
          if (exp_f_len.exists(ecnt)) chk("run_len", int'(o_run_len), exp_f_len[ecnt]);
          if (exp_d_cnt.exists(ecnt)) chk("count_at_done", int'(o_run_count), exp_d_cnt[ecnt]);
        end
      end
    join_none

    // Reset state
    tick(); tick();
    chk("rst_start", int'(o_start), 0);
    chk("rst_finish", int'(o_finish), 0);
    chk("rst_done", int'(o_line_done), 0);
    chk("rst_left", int'(o_left_edge), 0);
    chk("rst_count", int'(o_run_count), 0);
    rst = 1'b0;
    tick();
    chk_en = 1'b1;

    clear_pix(); set_ones(100, 119);
    drive_line(50, -1, 0, b1);
    idle(2);
    clear_pix(); set_ones(10, 12);
    drive_line(51, -1, 0, b2);
    idle(2);
    clear_pix(); set_ones(200, 209); set_ones(212, 215);
    drive_line(52, -1, 0, b3);
    idle(2);
    // Run confirmed on the eol pixel, next line streamed straight after it.
    clear_pix(); set_ones(636, 639);
    drive_line(53, -1, 0, b4);
    clear_pix(); set_ones(100, 119);
    drive_line(54, 110, 5, b5);
    idle(2);
    clear_pix();
    set_ones(20, 25); set_ones(29, 34); set_ones(50, 53); set_ones(60, 62);
    set_ones(64, 70); set_ones(630, 634);
    drive_line(55, -1, 0, b6);
    idle(3);

    // Reset while inside a run
    chk_en = 1'b0;
    clear_pix(); set_ones(300, 639);
    for (int k = 0; k <= 305; k++) begin
      i_valid = 1'b1; i_pixel = pix[k]; i_x = 10'(k); i_y = 9'd7; i_eol = 1'b0;
      tick();
      if (k == 303) begin
        chk("rr_start", int'(o_start), 1);
        chk("rr_left", int'(o_left_edge), 300);
        chk("rr_y", int'(o_y), 7);
      end
    end
    i_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rr_async_left", int'(o_left_edge), 0);
    chk("rr_async_y", int'(o_y), 0);
    chk("rr_async_len", int'(o_run_len), 0);
    chk("rr_async_count", int'(o_run_count), 0);
    chk("rr_async_finish", int'(o_finish), 0);
    tick();
    chk("rr_no_finish_1", int'(o_finish), 0);
    tick();
    chk("rr_no_finish_2", int'(o_finish), 0);
    rst = 1'b0;
    tick();
    chk_en = 1'b1;
    clear_pix(); set_ones(400, 409);
    drive_line(8, -1, 0, b8);
    idle(4);

    // Hand-computed pins on the reference lines
    chk("L1_start_left", got(0, b1 + 103), 100);
    chk("L1_start_y", got(1, b1 + 103), 50);
    chk("L1_finish_len", got(2, b1 + 122), 20);
    chk("L1_done_count", got(3, b1 + 639), 1);
    chk("L2_no_runs", n_events(b2, b2 + 640), 0);
    chk("L2_done_count", got(3, b2 + 639), 0);
    chk("L3_start_left", got(0, b3 + 203), 200);
    chk("L3_finish_len", got(2, b3 + 218), 16);
    chk("L3_done_count", got(3, b3 + 639), 1);
    chk("L4_start_left", got(0, b4 + 639), 636);
    chk("L4_finish_len", got(2, b4 + 640), 4);
    chk("L4_done_count", got(3, b4 + 640), 1);
    chk("L5_start_left", got(0, b5 + 103), 100);
    chk("L5_finish_len", got(2, b5 + 127), 20);
    chk("L6_last_len", got(2, b6 + 637), 5);
    chk("L6_done_count", got(3, b6 + 639), 5);
    chk("L8_start_left", got(0, b8 + 403), 400);
    chk("L8_start_y", got(1, b8 + 403), 8);
    chk("L8_finish_len", got(2, b8 + 412), 10);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
